// File: rtl/conv_encoder_noisy.sv
// Rate-1/N_OUT feed-forward convolutional encoder with trellis tail insertion and a
// deterministic bit-flip channel model; define CONV_ENC_NOISE_EN to build the noise injector.
module conv_encoder_noisy #(
  parameter int                 K            = 4,
  parameter int                 N_OUT        = 2,
  parameter logic [N_OUT*K-1:0] G            = 8'b1111_1011,
  parameter int                 NOISE_PERIOD = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic             noise_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             out_last
);

  localparam int HW = (K > 1) ? K - 1 : 1;
  localparam int TW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {S_RUN = 1'b0, S_TAIL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [HW-1:0]    r_hist;
  logic [HW-1:0]    w_hist_next;
  logic [TW-1:0]    r_tail_cnt;
  logic             r_out_valid;
  logic             r_out_last;
  logic [N_OUT-1:0] r_out_data;

  logic             w_out_free;
  logic             w_accept;
  logic             w_tail_enc;
  logic             w_encode;
  logic             w_start_tail;
  logic             w_bit;
  logic             w_last;
  logic [K-1:0]     w_window;
  logic [N_OUT-1:0] w_code;
  logic [N_OUT-1:0] w_mask;

  assign w_out_free   = !r_out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_tail_enc   = (r_state == S_TAIL) && w_out_free;
  assign w_encode     = w_accept || w_tail_enc;
  assign w_start_tail = w_accept && in_last && (K > 1);
  // Tail codewords encode a forced zero.
  assign w_bit        = (r_state == S_RUN) && in_bit;

  generate
    if (K > 1) begin : g_win
      assign w_window = {r_hist, w_bit};
    end else begin : g_win_k1
      logic w_unused_hist;
      assign w_window      = w_bit;
      assign w_unused_hist = ^r_hist;
    end

    if (K > 2) begin : g_hist
      assign w_hist_next = {r_hist[HW-2:0], w_bit};
    end else begin : g_hist_short
      assign w_hist_next = HW'(w_bit);
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_poly
      assign w_code[gi] = ^(G[gi*K +: K] & w_window);
    end
  endgenerate

`ifdef CONV_ENC_NOISE_EN
  localparam int CW = (NOISE_PERIOD > 1) ? $clog2(NOISE_PERIOD) : 1;
  localparam int SW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [CW-1:0] r_noise_cnt;
  logic [SW-1:0] r_noise_sel;
  logic          w_noise_hit;

  assign w_noise_hit = noise_en && (r_noise_cnt == CW'(NOISE_PERIOD - 1));
  assign w_mask      = w_noise_hit ? (N_OUT'(1) << r_noise_sel) : '0;

  // Counts only codewords encoded while the channel is enabled.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_noise_cnt <= '0;
      r_noise_sel <= '0;
    end else if (w_encode && noise_en) begin
      if (w_noise_hit) begin
        r_noise_cnt <= '0;
        r_noise_sel <= (r_noise_sel == SW'(N_OUT - 1)) ? '0 : r_noise_sel + SW'(1);
      end else begin
        r_noise_cnt <= r_noise_cnt + CW'(1);
      end
    end
  end
`else
  logic w_unused_noise_en;
  assign w_mask            = '0;
  assign w_unused_noise_en = noise_en;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (w_start_tail) w_state_next = S_TAIL;
      S_TAIL:  if (w_tail_enc && (r_tail_cnt == TW'(1))) w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_RUN: begin
        in_ready = w_out_free;
        w_last   = in_last && (K == 1);
      end
      S_TAIL:  w_last = (r_tail_cnt == TW'(1));
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_tail_cnt <= '0;
      r_hist     <= '0;
    end else begin
      if (w_start_tail) begin
        r_tail_cnt <= TW'(K - 1);
      end else if (w_tail_enc) begin
        r_tail_cnt <= r_tail_cnt - TW'(1);
      end
      if (w_encode) begin
        r_hist <= w_hist_next;
      end
    end
  end

  // Encoding into a draining register keeps full throughput.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_encode) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_code ^ w_mask;
      r_out_last  <= w_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule
